// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_share_arbiter
//  Purpose  : Round-robin sharing of one external combinational 16-bit
//             twos-complement adder between NUM_REQ valid/ready requesters,
//             with a single backpressured response channel.
//  Options  : ADDER_OVERFLOW_FLAG_EN adds the registered rsp_ovf output.
//  Revision : 1.0  initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  output logic                     adder_sub,
  input  logic [WIDTH-1:0]         adder_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
`ifdef ADDER_OVERFLOW_FLAG_EN
  output logic                     rsp_ovf,
`endif
  output logic                     busy
);

  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sub;
  logic [ID_W-1:0]   r_id;

  logic              w_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_next_ptr;
  logic              w_grant_fire;
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;
  logic              w_sel_sub;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int k;
    k         = 0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && req_valid[k]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(k);
      end
    end
  end

  assign w_grant_fire = (r_state == S_IDLE) && w_found;
  assign w_next_ptr   = (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + ID_W'(1);
  assign w_sel_a      = req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_sel_b      = req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_sel_sub    = req_sub[w_gnt_idx];

  // One-hot accept, only offered while idle; the ready itself is the grant.
  always_comb begin
    req_ready = '0;
    if (w_grant_fire) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: IDLE -> ADD on a grant, ADD -> RESP always, RESP -> IDLE on accept.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant_fire) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef ADDER_OVERFLOW_FLAG_EN
  logic w_ovf;

  // Signed overflow from the latched operand signs and the adder result sign.
  always_comb begin
    w_ovf = 1'b0;
    if (r_sub) begin
      w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (adder_sum[WIDTH-1] != r_a[WIDTH-1]);
    end else begin
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (adder_sum[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  // Overflow flag travels with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (r_state == S_ADD) begin
      rsp_ovf <= w_ovf;
    end
  end
`endif

  // Operands are sampled only on the grant cycle so later requester changes
  // cannot disturb the in-flight op; the sum is captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_id      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_fire) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_sub    <= w_sel_sub;
            r_id     <= w_gnt_idx;
            r_rr_ptr <= w_next_ptr;
          end
        end
        S_ADD: begin
          rsp_data  <= adder_sum;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign adder_a   = r_a;
  assign adder_b   = r_b;
  assign adder_sub = r_sub;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_share_arbiter
//  Purpose  : Directed self-checking bench for adder_share_arbiter, including
//             a behavioural model of the external shared adder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_share_arbiter;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sub;
  logic [WIDTH-1:0]         adder_a;
  logic [WIDTH-1:0]         adder_b;
  logic                     adder_sub;
  logic [WIDTH-1:0]         adder_sum;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic                     rsp_ovf;
`endif

  int total;
  int passed;
  int failed;

  adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_sub (adder_sub),
    .adder_sum (adder_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef ADDER_OVERFLOW_FLAG_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  // External combinational adder: a+b or a+~b+1.
  assign adder_sum = adder_sub ? (adder_a + ~adder_b + 16'd1) : (adder_a + adder_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated op on requester idx, held in RESP one cycle before accepting.
  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] exp, input logic exp_ovf);
    rsp_ready                = 1'b0;
    req_valid                = '0;
    req_valid[idx]           = 1'b1;
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_sub[idx]             = s;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << idx);
    step();
    req_valid[idx]            = 1'b0;
    req_a[idx*WIDTH +: WIDTH] = ~a;
    req_b[idx*WIDTH +: WIDTH] = ~b;
    #1;
    chk("add_busy",      32'(busy),      32'd1);
    chk("add_ready",     32'(req_ready), 32'd0);
    chk("add_adder_a",   32'(adder_a),   32'(a));
    chk("add_adder_b",   32'(adder_b),   32'(b));
    chk("add_adder_sub", 32'(adder_sub), 32'(s));
    chk("add_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data",  32'(rsp_data),  32'(exp));
    chk("rsp_id",    32'(rsp_id),    32'(idx));
`ifdef ADDER_OVERFLOW_FLAG_EN
    chk("rsp_ovf",   32'(rsp_ovf),   32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk("ovf_unused", 32'd0, 32'd1);
`endif
    rsp_ready = 1'b1;
    step();
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_busy",  32'(busy),      32'd0);
    rsp_ready = 1'b0;
  endtask

  logic [15:0] rr_exp [4];

  initial begin
    total     = 0;
    passed    = 0;
    failed    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_adder_a",   32'(adder_a),   32'd0);
    chk("rst_adder_b",   32'(adder_b),   32'd0);
    chk("rst_adder_sub", 32'(adder_sub), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_ready",     32'(req_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(req_ready), 32'd0);

    // Single ops
    do_op(0, 16'h7FFE, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
    do_op(2, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFE, 1'b0);
    do_op(2, 16'h7FFF, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    do_op(2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
    do_op(3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);

    // Round-robin from a fresh reset, all four held valid
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rr_exp[0] = 16'h1000;
    rr_exp[1] = 16'h2001;
    rr_exp[2] = 16'h3002;
    rr_exp[3] = 16'h4003;
    req_a   = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    req_b   = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    req_sub = 4'b0000;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      step();
      chk("rr_add_ready", 32'(req_ready), 32'd0);
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rr_rsp_id",    32'(rsp_id),    32'(k % 4));
      chk("rr_rsp_data",  32'(rsp_data),  32'(rr_exp[k % 4]));
      chk("rr_rsp_ready", 32'(req_ready), 32'd0);
      step();
      chk("rr_back_idle", 32'(rsp_valid), 32'd0);
    end

    // Backpressure: rr_ptr is now 1, req3 alone gets the grant
    req_valid = 4'b1000;
    req_a[3*WIDTH +: WIDTH] = 16'h0010;
    req_b[3*WIDTH +: WIDTH] = 16'h0020;
    req_sub[3] = 1'b1;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = 16'h1234;
    req_b[1*WIDTH +: WIDTH] = 16'h0001;
    req_sub[1] = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  32'(rsp_data),  32'hFFF0);
      chk("bp_id",    32'(rsp_id),    32'd3);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy",  32'(busy),      32'd1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_busy",  32'(busy),      32'd0);
    chk("bp_next_grant",    32'(req_ready), 32'h2);
    rsp_ready = 1'b0;

    // Reset during ADD discards the op and clears the pointer
    step();
    chk("mid_busy",    32'(busy),    32'd1);
    chk("mid_adder_a", 32'(adder_a), 32'h1234);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",   32'(rsp_valid), 32'd0);
    chk("mid_rst_busy",    32'(busy),      32'd0);
    chk("mid_rst_adder_a", 32'(adder_a),   32'd0);
    req_valid = 4'b1010;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h2);
    do_op(1, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
